// File: rtl/blink_seq_ctrl.sv
// Step-table scheduler that replays up to 8 blink-period steps into the blink core slot.
// Optional macro BLINK_SEQ_IRQ_EN adds a done interrupt (irq) with clear at address 3.
module blink_seq_ctrl #(
    parameter int CLK_PER_MS = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        m_cs,
    output logic        m_write,
    output logic [4:0]  m_addr,
    output logic [31:0] m_wr_data,
    output logic        busy
`ifdef BLINK_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    // Handshakes: a host access is one cycle of cs; a write commits on the edge where
    // cs && write, a read is combinational while cs && read. On the master side every
    // cycle with m_cs && m_write is one completed write; the core never stalls us.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);

    logic [1:0]    state;
    logic          run;
    logic          loop_en;
    logic [3:0]    step_len;
    logic [15:0]   dwell_tbl [8];
    logic [31:0]   per_tbl [8];
    logic [2:0]    step;
    logic [1:0]    ld_idx;
    logic [31:0]   per_lat;
    logic [15:0]   dwell_lat;
    logic [PW-1:0] presc;
    logic [15:0]   ms_cnt;
    logic          done;

    logic        wr_en;
    logic        ctrl_wr;
    logic        run_start;
    logic        abort;
    logic        busy_i;
    logic [3:0]  eff_len;
    logic [2:0]  last_step;
    logic [2:0]  next_step;
    logic [15:0] eff_dwell;
    logic        wrap;
    logic        dwell_hit;
    logic        finish;
    logic [7:0]  code;

    assign wr_en     = cs && write;
    assign ctrl_wr   = wr_en && (addr == 5'd0);
    assign busy_i    = (state == S_LOAD) || (state == S_DWELL);
    assign run_start = ctrl_wr && wr_data[0] && !busy_i;
    assign abort     = ctrl_wr && !wr_data[0] && busy_i;
    assign busy      = busy_i;

    always_comb begin
        eff_len = step_len;
        if (step_len == 4'd0) begin
            eff_len = 4'd1;
        end else if (step_len > 4'd8) begin
            eff_len = 4'd8;
        end
    end

    assign last_step = 3'(eff_len - 4'd1);
    assign next_step = (step == last_step) ? 3'd0 : step + 3'd1;
    assign eff_dwell = (dwell_lat == 16'd0) ? 16'd1 : dwell_lat;
    assign wrap      = (presc == PRESC_MAX);
    assign dwell_hit = (state == S_DWELL) && wrap && ((ms_cnt + 16'd1) == eff_dwell);
    // Abort has priority over a completion landing on the same edge.
    assign finish    = dwell_hit && !abort && (step == last_step) && !loop_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run      <= 1'b0;
            loop_en  <= 1'b0;
            step_len <= 4'd0;
            for (int k = 0; k < 8; k++) begin
                dwell_tbl[k] <= 16'd0;
                per_tbl[k]   <= 32'd0;
            end
        end else begin
            if (ctrl_wr) begin
                run     <= wr_data[0];
                loop_en <= wr_data[1];
            end
            if (finish) begin
                run <= 1'b0;
            end
            if (wr_en && (addr == 5'd2) && !busy_i) begin
                step_len <= wr_data[3:0];
            end
            if (wr_en && (addr[4:3] == 2'b01)) begin
                dwell_tbl[addr[2:0]] <= wr_data[15:0];
            end
            if (wr_en && (addr[4:3] == 2'b10)) begin
                per_tbl[addr[2:0]] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            step      <= 3'd0;
            ld_idx    <= 2'd0;
            per_lat   <= 32'd0;
            dwell_lat <= 16'd0;
            presc     <= '0;
            ms_cnt    <= 16'd0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (run_start) begin
                        step      <= 3'd0;
                        done      <= 1'b0;
                        ld_idx    <= 2'd0;
                        per_lat   <= per_tbl[0];
                        dwell_lat <= dwell_tbl[0];
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ld_idx <= ld_idx + 2'd1;
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (ld_idx == 2'd3) begin
                        presc  <= '0;
                        ms_cnt <= 16'd0;
                        state  <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (wrap) begin
                        presc <= '0;
                        if (dwell_hit) begin
                            if (finish) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                step      <= next_step;
                                ld_idx    <= 2'd0;
                                per_lat   <= per_tbl[next_step];
                                dwell_lat <= dwell_tbl[next_step];
                                state     <= S_LOAD;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 16'd1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BLINK_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (finish) begin
            irq <= 1'b1;
        end else if (run_start || (wr_en && (addr == 5'd3) && wr_data[0])) begin
            irq <= 1'b0;
        end
    end
`endif

    assign code      = per_lat[{ld_idx, 3'b000} +: 8];
    assign m_cs      = (state == S_LOAD);
    assign m_write   = (state == S_LOAD);
    assign m_addr    = (state == S_LOAD) ? {3'b000, ld_idx} : 5'd0;
    assign m_wr_data = (state == S_LOAD) ? {22'd0, code, 2'b00} : 32'd0;

    always_comb begin
        rd_data = 32'd0;
        if (cs && read) begin
            case (addr)
                5'd0: rd_data = {30'd0, loop_en, run};
                5'd1: rd_data = {23'd0, done, 1'b0, step, 3'b000, busy_i};
                5'd2: rd_data = {28'd0, step_len};
`ifdef BLINK_SEQ_IRQ_EN
                5'd3: rd_data = {31'd0, irq};
`endif
                default: begin
                    if (addr[4:3] == 2'b01) begin
                        rd_data = {16'd0, dwell_tbl[addr[2:0]]};
                    end else if (addr[4:3] == 2'b10) begin
                        rd_data = per_tbl[addr[2:0]];
                    end
                end
            endcase
        end
    end

endmodule
